sort_stream_ctrl: RTL

Sequencer that wraps the 8-entry byte sorter and gives it a stream interface. It accepts 8 bytes on a valid/ready input stream and writes them into the sorter. It then pulses the sorter's start, waits for completion and streams the 8 sorted bytes out on a valid/ready output with a last flag. It sits between a host/DMA stream and the sorter, owning every sorter control pin.

---
 rtl/sort_pkg.sv | 15 +
 rtl/sort_stream_ctrl.sv | 133 +++++++++++++
 2 files changed

// File: rtl/sort_pkg.sv
// rtl/sort_pkg.sv - shared types and sizes for the sorter stream controller
package sort_pkg;
  localparam int N  = 8;
  localparam int AW = 3;
  localparam int DW = 8;

  typedef enum logic [2:0] {
    LOAD   = 3'd0,
    SETTLE = 3'd1,
    START  = 3'd2,
    WAIT   = 3'd3,
    FETCH  = 3'd4,
    EMIT   = 3'd5
  } state_t;
endpackage

// File: rtl/sort_stream_ctrl.sv
// rtl/sort_stream_ctrl.sv - stream front end that loads, starts and drains the 8-entry byte sorter
// Optional SORT_PERF_EN adds the sort_cycles counter output.
module sort_stream_ctrl
  import sort_pkg::*;
#(
  parameter int DW     = sort_pkg::DW,
  parameter int N      = sort_pkg::N,
  parameter int RD_LAT = 2
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  output logic          busy,
  output logic          s_start,
  output logic          s_wr,
  output logic [AW-1:0] s_addr,
  output logic [DW-1:0] s_datain,
  input  logic [DW-1:0] s_dataout,
  input  logic          s_ready
`ifdef SORT_PERF_EN
  ,output logic [15:0]  sort_cycles
`endif
);

  localparam int LW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  state_t        state;
  logic [AW-1:0] count;
  logic [LW-1:0] lat;
  logic          guard;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state     <= LOAD;
      count     <= '0;
      lat       <= '0;
      guard     <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      s_start   <= 1'b0;
      s_wr      <= 1'b0;
      s_addr    <= '0;
      s_datain  <= '0;
`ifdef SORT_PERF_EN
      sort_cycles <= '0;
`endif
    end else begin
      // Strobes are single-cycle unless a state re-asserts them.
      s_start <= 1'b0;
      s_wr    <= 1'b0;
      case (state)
        LOAD: begin
          if (in_valid && in_ready) begin
            s_wr     <= 1'b1;
            s_addr   <= count;
            s_datain <= in_data;
            busy     <= 1'b1;
            if (count == AW'(N - 1)) begin
              count    <= '0;
              in_ready <= 1'b0;
              state    <= SETTLE;
            end else begin
              count <= count + 1'b1;
            end
          end
        end
        SETTLE: state <= START;
        START: begin
          s_start <= 1'b1;
          guard   <= 1'b1;
          state   <= WAIT;
`ifdef SORT_PERF_EN
          sort_cycles <= '0;
`endif
        end
        WAIT: begin
`ifdef SORT_PERF_EN
          if (sort_cycles != 16'hFFFF) sort_cycles <= sort_cycles + 16'd1;
`endif
          // s_ready may still show idle in the cycle right after the start pulse.
          if (!s_start) begin
            if (guard) begin
              guard <= 1'b0;
            end else if (s_ready) begin
              count  <= '0;
              s_addr <= '0;
              lat    <= '0;
              state  <= FETCH;
            end
          end
        end
        FETCH: begin
          if (lat == LW'(RD_LAT - 1)) begin
            out_data  <= s_dataout;
            out_valid <= 1'b1;
            out_last  <= (count == AW'(N - 1));
            state     <= EMIT;
          end else begin
            lat <= lat + 1'b1;
          end
        end
        EMIT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            if (out_last) begin
              busy     <= 1'b0;
              in_ready <= 1'b1;
              count    <= '0;
              state    <= LOAD;
            end else begin
              count  <= count + 1'b1;
              s_addr <= count + 1'b1;
              lat    <= '0;
              state  <= FETCH;
            end
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule
